// File: rtl/drink_buyer_if.sv
// Customer/vending-side bus of the drink buyer: purchase order in, coin stream out,
// vend confirmation back, and order status.
interface drink_buyer_if #(
  parameter int CW = 4,
  parameter int WW = 6
);
  logic          start;
  logic [CW-1:0] n_drinks;
  logic [WW-1:0] wallet_one;
  logic [WW-1:0] wallet_half;
  logic [1:0]    coin;
  logic          drink;
  logic [1:0]    back;
  logic          busy;
  logic          done;
  logic [CW-1:0] bought;
  logic [WW-1:0] change_half;
  logic          err;

  modport master (
    output start, n_drinks, wallet_one, wallet_half, drink, back,
    input  coin, busy, done, bought, change_half, err
  );

  modport slave (
    input  start, n_drinks, wallet_one, wallet_half, drink, back,
    output coin, busy, done, bought, change_half, err
  );
endinterface

// File: rtl/drink_buyer.sv
// Customer-side agent for the drink vending FSM: inserts coins from a latched wallet,
// confirms each vend against the money paid and tallies returned change.
module drink_buyer #(
  parameter int CW    = 4,
  parameter int WW    = 6,
  parameter int PRICE = 3
) (
  input  logic          clk,
  input  logic          reset,
  drink_buyer_if.slave  bus
);
  localparam int PW = $clog2(PRICE + 2);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_CHECK, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_n, w_n_nxt;
  logic [CW-1:0] r_bought, w_bought_nxt;
  logic [WW-1:0] r_one, w_one_nxt;
  logic [WW-1:0] r_half, w_half_nxt;
  logic [WW-1:0] r_change, w_change_nxt;
  logic [WW-1:0] w_src_one, w_src_half;
  logic [PW-1:0] r_paid, w_paid_nxt, w_src_paid, w_owed;
  logic [1:0]    r_coin, w_coin_nxt;
  logic          r_err, w_err_nxt;
  logic          w_load, w_paid_ok, w_back_ok;

  assign w_paid_ok = (r_paid >= PW'(PRICE));
  assign w_back_ok = (bus.back == 2'(r_paid - PW'(PRICE)));

  // The coin register is loaded on the edge that enters SELECT, so the coin is on the
  // bus during SELECT and the vending FSM answers during CHECK.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    w_state_nxt  = r_state;
    w_n_nxt      = r_n;
    w_bought_nxt = r_bought;
    w_one_nxt    = r_one;
    w_half_nxt   = r_half;
    w_change_nxt = r_change;
    w_paid_nxt   = r_paid;
    w_coin_nxt   = 2'b00;
    w_err_nxt    = r_err;
    w_load       = 1'b0;
    w_src_one    = r_one;
    w_src_half   = r_half;
    w_src_paid   = r_paid;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_n_nxt      = bus.n_drinks;
          w_bought_nxt = '0;
          w_change_nxt = '0;
          w_err_nxt    = 1'b0;
          w_paid_nxt   = '0;
          if (bus.n_drinks == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_load     = 1'b1;
            w_src_one  = bus.wallet_one;
            w_src_half = bus.wallet_half;
            w_src_paid = '0;
          end
        end
      end
      S_SELECT: begin
        // An empty coin slot here means the wallet could not cover the next insert.
        if (r_coin == 2'b00) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bus.drink && w_paid_ok) begin
          w_bought_nxt = r_bought + CW'(1);
          if (bus.back == 2'b01) w_change_nxt = r_change + WW'(1);
          if (!w_back_ok) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_paid_nxt = '0;
            if (w_bought_nxt == r_n) begin
              w_state_nxt = S_DONE;
            end else begin
              w_load     = 1'b1;
              w_src_paid = '0;
            end
          end
        end else if (!bus.drink && !w_paid_ok) begin
          w_load = 1'b1;
        end else begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_owed = PW'(PRICE) - w_src_paid;
    if (w_load) begin
      w_state_nxt = S_SELECT;
      w_one_nxt   = w_src_one;
      w_half_nxt  = w_src_half;
      w_paid_nxt  = w_src_paid;
      if (w_owed >= PW'(2) && w_src_one != '0) begin
        w_coin_nxt = 2'b10;
        w_one_nxt  = w_src_one - WW'(1);
        w_paid_nxt = w_src_paid + PW'(2);
      end else if (w_src_half != '0) begin
        w_coin_nxt = 2'b01;
        w_half_nxt = w_src_half - WW'(1);
        w_paid_nxt = w_src_paid + PW'(1);
      end else if (w_src_one != '0) begin
        w_coin_nxt = 2'b10;
        w_one_nxt  = w_src_one - WW'(1);
        w_paid_nxt = w_src_paid + PW'(2);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state  <= S_IDLE;
      r_n      <= '0;
      r_bought <= '0;
      r_one    <= '0;
      r_half   <= '0;
      r_change <= '0;
      r_paid   <= '0;
      r_coin   <= 2'b00;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_n      <= w_n_nxt;
      r_bought <= w_bought_nxt;
      r_one    <= w_one_nxt;
      r_half   <= w_half_nxt;
      r_change <= w_change_nxt;
      r_paid   <= w_paid_nxt;
      r_coin   <= w_coin_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign bus.coin        = r_coin;
  assign bus.busy        = (r_state == S_SELECT) || (r_state == S_CHECK);
  assign bus.done        = (r_state == S_DONE);
  assign bus.bought      = r_bought;
  assign bus.change_half = r_change;
  assign bus.err         = r_err;
endmodule

// File: tb/tb_drink_buyer.sv
// Bench for drink_buyer: a vending-machine model answers the coin stream, and an
// order-level model predicts the per-cycle outputs checked on every falling edge.
module tb_drink_buyer;
  localparam int CW    = 4;
  localparam int WW    = 6;
  localparam int PRICE = 3;

  typedef struct {
    logic [1:0] coin;
    bit         busy;
    bit         done;
    int         bought;
    int         change;
    bit         err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   v_credit = 0;
  bit   v_fault  = 1'b0;
  exp_t q[$];

  drink_buyer_if #(.CW(CW), .WW(WW)) bus ();

  drink_buyer #(.CW(CW), .WW(WW), .PRICE(PRICE)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Vending machine: takes the coin seen at a rising edge, answers during the next cycle.
  always @(posedge clk) begin : vending
    logic [1:0] c;
    c = bus.coin;
    #1;
    bus.drink = 1'b0;
    bus.back  = 2'b00;
    if (reset) begin
      v_credit = 0;
    end else begin
      if (c == 2'b10) v_credit += 2;
      else if (c == 2'b01) v_credit += 1;
      if (v_credit >= PRICE && !(v_fault && v_credit == PRICE)) begin
        bus.drink = 1'b1;
        bus.back  = 2'(v_credit - PRICE);
        v_credit  = 0;
      end
    end
  end

  function automatic void push(input logic [1:0] c, input bit bz, input bit dn,
                               input int b, input int ch, input bit e);
    exp_t x;
    x.coin = c; x.busy = bz; x.done = dn; x.bought = b; x.change = ch; x.err = e;
    q.push_back(x);
  endfunction

  // Order-level prediction: walk the purchase coin by coin, two cycles per coin.
  function automatic void build(input int n, input int one, input int half,
                                input int credit, input bit fault);
    int b, ch, paid, v, owed, backv;
    bit er, fin, vend;
    b = 0; ch = 0; paid = 0; er = 1'b0; fin = (n == 0);
    while (!fin) begin
      owed = PRICE - paid;
      if (owed >= 2 && one > 0) begin v = 2; one--; end
      else if (half > 0) begin v = 1; half--; end
      else if (one > 0) begin v = 2; one--; end
      else v = 0;
      if (v == 0) begin
        push(2'b00, 1, 0, b, ch, 0);
        er = 1'b1; fin = 1'b1;
      end else begin
        push((v == 2) ? 2'b10 : 2'b01, 1, 0, b, ch, 0);
        push(2'b00, 1, 0, b, ch, 0);
        paid += v; credit += v; backv = 0;
        vend = (credit >= PRICE) && !(fault && credit == PRICE);
        if (vend) begin backv = credit - PRICE; credit = 0; end
        if (vend && paid >= PRICE) begin
          b++;
          if (backv == 1) ch++;
          if (backv != paid - PRICE) begin er = 1'b1; fin = 1'b1; end
          else begin paid = 0; if (b == n) fin = 1'b1; end
        end else if (!(!vend && paid < PRICE)) begin
          er = 1'b1; fin = 1'b1;
        end
      end
    end
    push(2'b00, 0, 1, b, ch, er);
    push(2'b00, 0, 0, b, ch, er);
  endfunction

  always @(negedge clk) begin : compare
    exp_t e;
    if (!reset && q.size() > 0) begin
      e = q.pop_front();
      check("coin",   int'(bus.coin),        int'(e.coin));
      check("busy",   int'(bus.busy),        int'(e.busy));
      check("done",   int'(bus.done),        int'(e.done));
      check("bought", int'(bus.bought),      e.bought);
      check("change", int'(bus.change_half), e.change);
      check("err",    int'(bus.err),         int'(e.err));
    end
  end

  task automatic run_order(input string tag, input int n, input int one, input int half,
                           input int glitch, input int x_busy, input int x_bought,
                           input int x_change, input int x_err);
    int cyc, busy_cnt, done_cnt;
    @(negedge clk);
    bus.n_drinks    = CW'(n);
    bus.wallet_one  = WW'(one);
    bus.wallet_half = WW'(half);
    bus.start       = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    build(n, one, half, v_credit, v_fault);
    cyc = 0; busy_cnt = 0; done_cnt = 0;
    while (q.size() != 0 && cyc < 200) begin
      #2;
      if (bus.busy) busy_cnt++;
      if (bus.done) done_cnt++;
      if (cyc == glitch) begin
        bus.n_drinks = CW'(5);
        bus.start    = 1'b1;
      end
      @(posedge clk);
      #1 bus.start = 1'b0;
      cyc++;
    end
    if (cyc >= 200) begin
      check({tag, " timeout"}, cyc, 0);
      q.delete();
    end
    check({tag, " busy_cycles"}, busy_cnt, x_busy);
    check({tag, " done_pulses"}, done_cnt, 1);
    check({tag, " bought"}, int'(bus.bought), x_bought);
    check({tag, " change"}, int'(bus.change_half), x_change);
    check({tag, " err"}, int'(bus.err), x_err);
  endtask

  initial begin
    bus.start = 1'b0; bus.n_drinks = '0; bus.wallet_one = '0; bus.wallet_half = '0;
    bus.drink = 1'b0; bus.back = 2'b00;
    #50;
    check("rst coin",   int'(bus.coin), 0);
    check("rst busy",   int'(bus.busy), 0);
    check("rst done",   int'(bus.done), 0);
    check("rst bought", int'(bus.bought), 0);
    check("rst change", int'(bus.change_half), 0);
    check("rst err",    int'(bus.err), 0);
    #50 reset = 1'b0;

    run_order("t1", 1, 1, 1, -1, 4, 1, 0, 0);
    run_order("t2", 1, 2, 0, -1, 4, 1, 1, 0);
    run_order("t3", 2, 0, 6, -1, 12, 2, 0, 0);
    run_order("t4", 2, 1, 1, -1, 5, 1, 0, 1);
    run_order("t0", 0, 3, 3, -1, 0, 0, 0, 0);

    // Abandon an order in CHECK of its first coin.
    @(negedge clk);
    bus.n_drinks = CW'(1); bus.wallet_one = WW'(1); bus.wallet_half = WW'(1);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    build(1, 1, 1, v_credit, v_fault);
    @(posedge clk);
    #2;
    check("t5 busy_in_check", int'(bus.busy), 1);
    reset = 1'b1;
    q.delete();
    #1;
    check("t5 coin",   int'(bus.coin), 0);
    check("t5 busy",   int'(bus.busy), 0);
    check("t5 done",   int'(bus.done), 0);
    check("t5 bought", int'(bus.bought), 0);
    check("t5 change", int'(bus.change_half), 0);
    check("t5 err",    int'(bus.err), 0);
    repeat (3) begin
      @(negedge clk);
      check("t5 no_done", int'(bus.done), 0);
    end
    #2 reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("t5 idle_done", int'(bus.done), 0);
    end
    run_order("t5b", 1, 1, 1, -1, 4, 1, 0, 0);

    // Vending machine withholds the drink at exact payment; a start mid-order is ignored.
    v_fault = 1'b1;
    run_order("t6", 1, 1, 1, 1, 4, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
